issue_scheduler: RTL and testbench

Wakeup/select controller for the out-of-order instruction queue. It tracks which queue slots hold live instructions and whether each slot's physical source operands are ready. It watches result-tag broadcasts from writeback and picks the single oldest ready slot to issue each cycle. It also removes slots younger than a mispredicted branch on flush. Payload storage stays in the queue RAM; this block only produces slot indices and the handshakes around them.

---
 rtl/mips_core_pkg.sv | 21 ++
 rtl/iq_age_select.sv | 52 +++++
 rtl/issue_scheduler.sv | 146 ++++++++++++++
 tb/tb_issue_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types: physical register tags, active-list indices, and the
// wrap-around age compare used by both the issue queue and the active list.
package mips_core_pkg;

    localparam int IQ_DEPTH = 32;

    typedef logic [5:0] PhysReg;
    typedef logic [4:0] ActiveListIdx;

    // True when a is strictly younger than b, measuring distance from the oldest entry (head).
    function automatic logic al_younger(input ActiveListIdx a,
                                        input ActiveListIdx b,
                                        input ActiveListIdx head);
        ActiveListIdx dist_a;
        ActiveListIdx dist_b;
        dist_a = a - head;
        dist_b = b - head;
        return dist_a > dist_b;
    endfunction

endpackage

// File: rtl/iq_age_select.sv
// Age-matrix oldest-first selector. Row i holds a 1 in column j when slot j
// is older than slot i. A granted request is one with no older request.
module iq_age_select #(
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic [DEPTH-1:0]           set_mask,
    input  logic [DEPTH-1:0]           older,
    input  logic [DEPTH-1:0]           clear_mask,
    input  logic [DEPTH-1:0]           req,
    output logic [DEPTH-1:0]           grant,
    output logic [$clog2(DEPTH)-1:0]   grant_idx,
    output logic                       grant_any
);

    localparam int IW = $clog2(DEPTH);

    // Rows of dead slots may hold stale bits; they are rewritten on allocation
    // and never consulted while the slot is not requesting.
    logic [DEPTH-1:0] age [DEPTH];

    // Write the new slot's row on allocation; drop columns of slots leaving the queue.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (set_mask[i]) begin
                age[i] <= older;
            end else begin
                age[i] <= age[i] & ~clear_mask;
            end
        end
    end

    // Grant every request that has no older request (exactly one when any request exists).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = req[i] && !(|(age[i] & req));
        end
    end

    // Encode the one-hot grant.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | IW'(i);
            end
        end
    end

    assign grant_any = |grant;

endmodule

// File: rtl/issue_scheduler.sv
// Issue-queue wakeup/select controller: tracks slot liveness and source
// readiness, wakes slots on writeback tag broadcasts, issues the oldest ready
// slot, and squashes slots younger than a mispredicted branch.
module issue_scheduler
    import mips_core_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int PREG_W = $bits(PhysReg),
    parameter int AL_W   = $bits(ActiveListIdx),
    parameter int N_WB   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    output logic [$clog2(DEPTH)-1:0]   alloc_idx,
    input  logic [2*PREG_W-1:0]        alloc_src_tag,
    input  logic [1:0]                 alloc_src_rdy,
    input  logic [AL_W-1:0]            alloc_al_idx,
    input  logic [N_WB-1:0]            wb_valid,
    input  logic [N_WB*PREG_W-1:0]     wb_tag,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [$clog2(DEPTH)-1:0]   iss_idx,
    output logic [AL_W-1:0]            iss_al_idx,
    input  logic [AL_W-1:0]            al_head,
    input  logic                       flush_valid,
    input  logic [AL_W-1:0]            flush_al_idx,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]  live;
    logic [DEPTH-1:0]  live_next;
    logic [DEPTH-1:0]  req;
    logic [DEPTH-1:0]  grant;
    logic [DEPTH-1:0]  kill;
    logic [DEPTH-1:0]  set_mask;
    logic [DEPTH-1:0]  clear_mask;
    logic [PREG_W-1:0] src_tag [DEPTH][2];
    logic [1:0]        src_rdy [DEPTH];
    logic [AL_W-1:0]   slot_al [DEPTH];
    logic [1:0]        wake    [DEPTH];
    logic [1:0]        alloc_hit;
    logic [IW-1:0]     free_idx;
    logic [IW-1:0]     grant_idx;
    logic              grant_any;
    logic              alloc_fire;
    logic              iss_fire;

    // Flush masks both handshakes; a slot freed by issue only shows up via count next cycle.
    assign alloc_ready = !flush_valid && (count != CW'(DEPTH));
    assign alloc_idx   = free_idx;
    assign iss_valid   = grant_any && !flush_valid;
    assign iss_idx     = grant_idx;
    assign iss_al_idx  = grant_any ? slot_al[grant_idx] : '0;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign iss_fire    = iss_valid && iss_ready;

    // Lowest-numbered free slot.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!live[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    // Tag match of every stored source and of the incoming sources against this cycle's broadcasts.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < 2; k++) begin
                wake[i][k] = 1'b0;
                for (int p = 0; p < N_WB; p++) begin
                    if (wb_valid[p] && (wb_tag[p*PREG_W +: PREG_W] == src_tag[i][k])) begin
                        wake[i][k] = 1'b1;
                    end
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            alloc_hit[k] = 1'b0;
            for (int p = 0; p < N_WB; p++) begin
                if (wb_valid[p] && (wb_tag[p*PREG_W +: PREG_W] == alloc_src_tag[k*PREG_W +: PREG_W])) begin
                    alloc_hit[k] = 1'b1;
                end
            end
        end
    end

    // Candidates, flush kills, and the next live vector (flush > issue > allocate).
    always_comb begin
        kill     = '0;
        set_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            req[i]  = live[i] && (&src_rdy[i]);
            kill[i] = flush_valid && live[i] && al_younger(slot_al[i], flush_al_idx, al_head);
        end
        if (alloc_fire) begin
            set_mask[free_idx] = 1'b1;
        end
        clear_mask = kill | (iss_fire ? grant : '0);
        live_next  = (live & ~clear_mask) | set_mask;
    end

    iq_age_select #(
        .DEPTH(DEPTH)
    ) u_age_select (
        .clk        (clk),
        .set_mask   (set_mask),
        .older      (live & ~clear_mask),
        .clear_mask (clear_mask),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    // Slot liveness and occupancy; count always mirrors the registered live bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live  <= '0;
            count <= '0;
        end else begin
            live  <= live_next;
            count <= CW'($countones(live_next));
        end
    end

    // Per-slot payload: ready bits accumulate on wakeup; allocation overwrites the slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            src_rdy[i] <= src_rdy[i] | wake[i];
        end
        if (alloc_fire) begin
            src_tag[free_idx][0] <= alloc_src_tag[PREG_W-1:0];
            src_tag[free_idx][1] <= alloc_src_tag[2*PREG_W-1:PREG_W];
            src_rdy[free_idx]    <= alloc_src_rdy | alloc_hit;
            slot_al[free_idx]    <= alloc_al_idx;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: a directed vector table, hand
// sequences for the multi-cycle corners, and randomized traffic against a
// sequence-number based reference model of the queue.
module tb_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [4:0]  alloc_idx;
    logic [11:0] alloc_src_tag;
    logic [1:0]  alloc_src_rdy;
    logic [4:0]  alloc_al_idx;
    logic [1:0]  wb_valid;
    logic [11:0] wb_tag;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_idx;
    logic [4:0]  iss_al_idx;
    logic [4:0]  al_head;
    logic        flush_valid;
    logic [4:0]  flush_al_idx;
    logic [5:0]  count;

    issue_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_valid   (alloc_valid),
        .alloc_ready   (alloc_ready),
        .alloc_idx     (alloc_idx),
        .alloc_src_tag (alloc_src_tag),
        .alloc_src_rdy (alloc_src_rdy),
        .alloc_al_idx  (alloc_al_idx),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_idx       (iss_idx),
        .iss_al_idx    (iss_al_idx),
        .al_head       (al_head),
        .flush_valid   (flush_valid),
        .flush_al_idx  (flush_al_idx),
        .count         (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each live slot carries a program-order sequence number.
    bit          m_live [32];
    bit   [1:0]  m_rdy  [32];
    logic [5:0]  m_tag  [32][2];
    int          m_seq  [32];
    int          seq_ctr;
    int          flush_seq;
    bit          e_valid;
    bit          e_ar;
    int          e_best;
    int          e_free;

    typedef struct {
        bit av;
        bit ir;
        bit exp_iv;
        int exp_idx;
        int exp_cnt;
        bit exp_ar;
        int exp_aidx;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [5:0] t);
        for (int p = 0; p < 2; p++) begin
            if (wb_valid[p] && (wb_tag[p*6 +: 6] == t)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int head_seq();
        int h;
        h = seq_ctr;
        for (int i = 0; i < 32; i++) begin
            if (m_live[i] && m_seq[i] < h) h = m_seq[i];
        end
        return h;
    endfunction

    task automatic check_outputs();
        int cnt;
        cnt    = 0;
        e_free = -1;
        e_best = -1;
        for (int i = 0; i < 32; i++) begin
            if (m_live[i]) begin
                cnt++;
                if (m_rdy[i] == 2'b11 && (e_best < 0 || m_seq[i] < m_seq[e_best])) e_best = i;
            end else if (e_free < 0) begin
                e_free = i;
            end
        end
        e_ar    = !flush_valid && cnt < 32;
        e_valid = !flush_valid && e_best >= 0;
        chk("count", int'(count), cnt);
        chk("alloc_ready", int'(alloc_ready), int'(e_ar));
        if (e_free >= 0) chk("alloc_idx", int'(alloc_idx), e_free);
        chk("iss_valid", int'(iss_valid), int'(e_valid));
        if (e_valid) begin
            chk("iss_idx", int'(iss_idx), e_best);
            chk("iss_al_idx", int'(iss_al_idx), m_seq[e_best] & 31);
        end
    endtask

    task automatic model_update();
        int slot;
        if (flush_valid) begin
            for (int i = 0; i < 32; i++) begin
                if (m_live[i] && m_seq[i] > flush_seq) m_live[i] = 1'b0;
            end
        end
        for (int i = 0; i < 32; i++) begin
            if (m_live[i]) begin
                for (int k = 0; k < 2; k++) begin
                    if (hit(m_tag[i][k])) m_rdy[i][k] = 1'b1;
                end
            end
        end
        if (flush_valid) begin
            seq_ctr = flush_seq + 1;
        end else begin
            if (e_valid && iss_ready) m_live[e_best] = 1'b0;
            if (alloc_valid && e_ar) begin
                slot            = e_free;
                m_live[slot]    = 1'b1;
                m_tag[slot][0]  = alloc_src_tag[5:0];
                m_tag[slot][1]  = alloc_src_tag[11:6];
                m_rdy[slot]     = alloc_src_rdy | {hit(alloc_src_tag[11:6]), hit(alloc_src_tag[5:0])};
                m_seq[slot]     = seq_ctr;
                seq_ctr++;
            end
        end
    endtask

    // One model-checked cycle: drive derived inputs, compare, advance model and clock.
    task automatic tick();
        al_head      = 5'(head_seq());
        alloc_al_idx = 5'(seq_ctr);
        flush_al_idx = 5'(flush_seq);
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid   = 1'b0;
        alloc_src_tag = '0;
        alloc_src_rdy = 2'b00;
        alloc_al_idx  = '0;
        wb_valid      = 2'b00;
        wb_tag        = '0;
        iss_ready     = 1'b0;
        al_head       = '0;
        flush_valid   = 1'b0;
        flush_al_idx  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < 32; i++) m_live[i] = 1'b0;
        seq_ctr   = 0;
        flush_seq = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_alloc(input bit v, input int t0, input int t1, input bit [1:0] r);
        alloc_valid   = v;
        alloc_src_tag = {6'(t1), 6'(t0)};
        alloc_src_rdy = r;
    endtask

    task automatic set_wb(input bit [1:0] v, input int t0, input int t1);
        wb_valid = v;
        wb_tag   = {6'(t1), 6'(t0)};
    endtask

    int   q_live [$];
    int   hs;
    int   pick;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 0, 1, 1'b1, 1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 0, 2, 1'b1, 2};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 0, 3, 1'b1, 3};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1, 2, 1'b1, 0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 2, 1, 1'b1, 0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 0};

        // Reset values.
        do_reset();
        chk("rst_count", int'(count), 0);
        chk("rst_alloc_ready", int'(alloc_ready), 1);
        chk("rst_alloc_idx", int'(alloc_idx), 0);
        chk("rst_iss_valid", int'(iss_valid), 0);
        chk("rst_iss_idx", int'(iss_idx), 0);
        chk("rst_iss_al_idx", int'(iss_al_idx), 0);

        // Table: allocate three ready instructions, then drain them oldest first.
        for (int i = 0; i < 7; i++) begin
            alloc_valid   = tbl[i].av;
            iss_ready     = tbl[i].ir;
            alloc_src_tag = '0;
            alloc_src_rdy = 2'b11;
            alloc_al_idx  = 5'(i);
            #1;
            chk($sformatf("tbl%0d_iss_valid", i), int'(iss_valid), int'(tbl[i].exp_iv));
            if (tbl[i].exp_iv) chk($sformatf("tbl%0d_iss_idx", i), int'(iss_idx), tbl[i].exp_idx);
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_alloc_ready", i), int'(alloc_ready), int'(tbl[i].exp_ar));
            chk($sformatf("tbl%0d_alloc_idx", i), int'(alloc_idx), tbl[i].exp_aidx);
            @(posedge clk);
            #1;
        end

        // Younger ready slot issues before an older waiting one; wakeup visible next cycle.
        do_reset();
        iss_ready = 1'b1;
        set_alloc(1'b1, 12, 0, 2'b10);
        tick();
        set_alloc(1'b1, 1, 1, 2'b11);
        tick();
        set_alloc(1'b0, 0, 0, 2'b00);
        #1;
        chk("wait_first_iss_valid", int'(iss_valid), 1);
        chk("wait_first_iss_idx", int'(iss_idx), 1);
        tick();
        set_wb(2'b01, 12, 0);
        #1;
        chk("wake_same_cycle_iss_valid", int'(iss_valid), 0);
        tick();
        set_wb(2'b00, 0, 0);
        #1;
        chk("wake_next_iss_valid", int'(iss_valid), 1);
        chk("wake_next_iss_idx", int'(iss_idx), 0);
        tick();

        // Allocate-cycle bypass of a matching broadcast.
        do_reset();
        iss_ready = 1'b1;
        set_alloc(1'b1, 7, 0, 2'b10);
        set_wb(2'b10, 3, 7);
        tick();
        set_alloc(1'b0, 0, 0, 2'b00);
        set_wb(2'b00, 0, 0);
        #1;
        chk("bypass_iss_valid", int'(iss_valid), 1);
        chk("bypass_iss_idx", int'(iss_idx), 0);
        tick();

        // Fill all slots, then free one by issue.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            set_alloc(1'b1, i, i, 2'b00);
            tick();
        end
        set_alloc(1'b0, 0, 0, 2'b00);
        set_wb(2'b01, 5, 0);
        #1;
        chk("full_count", int'(count), 32);
        chk("full_alloc_ready", int'(alloc_ready), 0);
        tick();
        set_wb(2'b00, 0, 0);
        iss_ready = 1'b1;
        set_alloc(1'b1, 40, 40, 2'b00);
        #1;
        chk("full_iss_idx", int'(iss_idx), 5);
        chk("full_issue_cycle_alloc_ready", int'(alloc_ready), 0);
        tick();
        set_alloc(1'b0, 0, 0, 2'b00);
        iss_ready = 1'b0;
        #1;
        chk("freed_alloc_ready", int'(alloc_ready), 1);
        chk("freed_alloc_idx", int'(alloc_idx), 5);
        chk("freed_count", int'(count), 31);
        tick();

        // Flush with active-list wrap: al_idx {30,31,0,1}, branch 31.
        do_reset();
        seq_ctr = 30;
        for (int i = 0; i < 4; i++) begin
            set_alloc(1'b1, 0, 0, 2'b11);
            tick();
        end
        set_alloc(1'b1, 0, 0, 2'b11);
        flush_valid = 1'b1;
        flush_seq   = 31;
        #1;
        chk("flush_iss_valid", int'(iss_valid), 0);
        chk("flush_alloc_ready", int'(alloc_ready), 0);
        tick();
        set_alloc(1'b0, 0, 0, 2'b00);
        flush_valid = 1'b0;
        #1;
        chk("flush_count", int'(count), 2);
        chk("flush_survivor_iss_valid", int'(iss_valid), 1);
        chk("flush_survivor_iss_idx", int'(iss_idx), 0);
        chk("flush_survivor_al_idx", int'(iss_al_idx), 30);
        tick();

        // Asynchronous reset in the middle of issuing.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_alloc(1'b1, 0, 0, 2'b11);
            tick();
        end
        set_alloc(1'b0, 0, 0, 2'b00);
        iss_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        #2;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_iss_valid", int'(iss_valid), 0);
        chk("async_rst_alloc_ready", int'(alloc_ready), 1);
        chk("async_rst_alloc_idx", int'(alloc_idx), 0);
        chk("async_rst_iss_al_idx", int'(iss_al_idx), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            hs = head_seq();
            set_alloc(((seq_ctr - hs) < 31) && ($urandom_range(0, 9) < 7),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)));
            set_wb(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            iss_ready   = 1'($urandom_range(0, 1));
            flush_valid = 1'b0;
            q_live.delete();
            for (int i = 0; i < 32; i++) begin
                if (m_live[i]) q_live.push_back(i);
            end
            if (q_live.size() > 0 && $urandom_range(0, 29) == 0) begin
                pick        = q_live[$urandom_range(0, q_live.size() - 1)];
                flush_valid = 1'b1;
                flush_seq   = m_seq[pick];
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
